// File: rtl/event_counter_bank_pkg.sv
// Shared constants and helpers for the event counter bank.
// Direction encoding, parameter bounds and the load channel select width.
package event_counter_bank_pkg;

    localparam logic ECB_DIR_UP   = 1'b1;
    localparam logic ECB_DIR_DOWN = 1'b0;

    localparam int ECB_MAX_CHANNELS = 16;
    localparam int ECB_MAX_WIDTH    = 32;

    // A single-channel bank still needs a one-bit select port.
    function automatic int ecb_chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/event_counter_channel.sv
// One up/down counter with a one-cycle wrap pulse and a sticky overflow flag.
// Macro EVENT_COUNTER_BANK_SATURATE_EN: saturate at the boundaries instead of wrapping.
module event_counter_channel
    import event_counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] up_bound_value;
    logic [WIDTH-1:0] down_bound_value;
    logic [WIDTH-1:0] next_count;
    logic             wrap_event;

    // Value taken when a step hits the boundary in each direction.
    always_comb begin
`ifdef EVENT_COUNTER_BANK_SATURATE_EN
        up_bound_value   = limit;
        down_bound_value = ZERO;
`else
        up_bound_value   = ZERO;
        down_bound_value = limit;
`endif
    end

    // Next count and wrap event; load outranks counting.
    always_comb begin
        next_count = count;
        wrap_event = 1'b0;
        if (load) begin
            next_count = load_value;
        end else if (enable) begin
            if (up_down == ECB_DIR_UP) begin
                // ">=" so a count loaded above the limit wraps on its first up-step.
                if (count >= limit) begin
                    next_count = up_bound_value;
                    wrap_event = 1'b1;
                end else begin
                    next_count = count + ONE;
                end
            end else begin
                if (count == ZERO) begin
                    next_count = down_bound_value;
                    wrap_event = 1'b1;
                end else begin
                    next_count = count - ONE;
                end
            end
        end else begin
            next_count = count;
        end
    end

    // Count, pulse and sticky flag registers; a set beats a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= ZERO;
            wrap_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            count      <= next_count;
            wrap_pulse <= wrap_event;
            if (wrap_event) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
        end
    end

endmodule

// File: rtl/event_counter_bank.sv
// Bank of independent up/down event counters sharing one wrap limit.
// Macro EVENT_COUNTER_BANK_SATURATE_EN (in event_counter_channel) selects saturation.
module event_counter_bank
    import event_counter_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [CHANNELS-1:0]                   enable,
    input  logic [CHANNELS-1:0]                   up_down,
    input  logic [WIDTH-1:0]                      limit,
    input  logic                                  load_valid,
    input  logic [ecb_chan_width(CHANNELS)-1:0]   load_chan,
    input  logic [WIDTH-1:0]                      load_value,
    input  logic [CHANNELS-1:0]                   ovf_clear,
    output logic [CHANNELS*WIDTH-1:0]             count_out,
    output logic [CHANNELS-1:0]                   wrap_pulse,
    output logic [CHANNELS-1:0]                   overflow_out,
    output logic                                  any_overflow
);

    localparam int CHAN_W = ecb_chan_width(CHANNELS);

    logic [CHANNELS-1:0] load_hit;

    // Select values at or above CHANNELS match no instance and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign load_hit[i] = load_valid && (load_chan == CHAN_W'(i));

        event_counter_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable[i]),
            .up_down    (up_down[i]),
            .limit      (limit),
            .load       (load_hit[i]),
            .load_value (load_value),
            .ovf_clear  (ovf_clear[i]),
            .count      (count_out[i*WIDTH +: WIDTH]),
            .wrap_pulse (wrap_pulse[i]),
            .overflow   (overflow_out[i])
        );
    end

    assign any_overflow = |overflow_out;

endmodule

// File: tb/tb_event_counter_bank.sv
// Scoreboard bench for event_counter_bank (4 x 8-bit), plus a 3-channel instance
// for out-of-range load selects. Honours EVENT_COUNTER_BANK_SATURATE_EN.
module tb_event_counter_bank;

`ifdef EVENT_COUNTER_BANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [3:0]  enable;
    logic [3:0]  up_down;
    logic [7:0]  limit;
    logic        load_valid;
    logic [1:0]  load_chan;
    logic [7:0]  load_value;
    logic [3:0]  ovf_clear;
    logic [31:0] count_out;
    logic [3:0]  wrap_pulse;
    logic [3:0]  overflow_out;
    logic        any_overflow;

    logic        load_valid3;
    logic [1:0]  load_chan3;
    logic [23:0] count_out3;
    logic [2:0]  wrap_pulse3;
    logic [2:0]  overflow_out3;
    logic        any_overflow3;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  m_count [4];
    logic [3:0]  m_pulse;
    logic [3:0]  m_ovf;
    logic [40:0] sb [$];
    logic [40:0] exp_v;
    logic [40:0] obs_v;

    event_counter_bank #(.CHANNELS(4), .WIDTH(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .limit(limit), .load_valid(load_valid), .load_chan(load_chan),
        .load_value(load_value), .ovf_clear(ovf_clear), .count_out(count_out),
        .wrap_pulse(wrap_pulse), .overflow_out(overflow_out), .any_overflow(any_overflow)
    );

    event_counter_bank #(.CHANNELS(3), .WIDTH(8)) dut3 (
        .clock(clock), .reset(reset), .enable(3'b000), .up_down(3'b000),
        .limit(8'd9), .load_valid(load_valid3), .load_chan(load_chan3),
        .load_value(8'hAA), .ovf_clear(3'b000), .count_out(count_out3),
        .wrap_pulse(wrap_pulse3), .overflow_out(overflow_out3), .any_overflow(any_overflow3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: advance one edge from the driven inputs, push expectation, clock.
    task automatic step();
        logic [7:0] c;
        logic       w;
        for (int i = 0; i < 4; i++) begin
            c = m_count[i];
            w = 1'b0;
            if (reset) begin
                c = 8'd0;
                m_ovf[i] = 1'b0;
            end else if (load_valid && (int'(load_chan) == i)) begin
                c = load_value;
            end else if (enable[i] && up_down[i]) begin
                if (c >= limit) begin w = 1'b1; c = SAT ? limit : 8'd0; end
                else c = c + 8'd1;
            end else if (enable[i]) begin
                if (c == 8'd0) begin w = 1'b1; c = SAT ? 8'd0 : limit; end
                else c = c - 8'd1;
            end
            if (!reset) m_ovf[i] = w ? 1'b1 : (ovf_clear[i] ? 1'b0 : m_ovf[i]);
            m_count[i] = c;
            m_pulse[i] = w;
        end
        sb.push_back({m_count[3], m_count[2], m_count[1], m_count[0], m_pulse, m_ovf, |m_ovf});
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 4'b0000; up_down = 4'b0000; limit = 8'd0; load_valid = 1'b0;
        load_chan = 2'd0; load_value = 8'd0; ovf_clear = 4'b0000;
        load_valid3 = 1'b0; load_chan3 = 2'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) reset = 1'b0;
            step();
            exp_v = (sb.size() > 0) ? sb.pop_front() : 41'h1_FFFF_FFFF_FF;
            obs_v = {count_out, wrap_pulse, overflow_out, any_overflow};
            n_cmp++;
            if (obs_v !== exp_v || obs_v !== 41'd0) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %h expected %h", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_up_wrap();
        limit = 8'd9; enable = 4'b0001; up_down = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_v = sb.pop_front();
            obs_v = {count_out, wrap_pulse, overflow_out, any_overflow};
            n_cmp++;
            if (obs_v !== exp_v || count_out[7:0] !== 8'((k + 1) % 10)
                || wrap_pulse[0] !== (k == 9)) begin
                n_err++;
                $display("FAIL up_wrap cyc %0d: got %h expected %h", k, obs_v, exp_v);
            end
        end
        n_cmp++;
        if (overflow_out !== 4'b0001 || any_overflow !== 1'b1 || count_out[31:8] !== 24'd0) begin
            n_err++;
            $display("FAIL up_wrap_flags: got ovf %b any %b hi %h expected 0001 1 000000",
                     overflow_out, any_overflow, count_out[31:8]);
        end
    endtask

    task automatic test_down_clear();
        logic [7:0] seq [7];
        seq = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd5};
        limit = 8'd5; enable = 4'b0010; up_down = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            ovf_clear = (k >= 6) ? 4'b0010 : 4'b0000;
            if (k == 7) enable = 4'b0000;
            step();
            exp_v = sb.pop_front();
            obs_v = {count_out, wrap_pulse, overflow_out, any_overflow};
            n_cmp++;
            if (obs_v !== exp_v || (k < 7 && count_out[15:8] !== seq[k])
                || overflow_out[1] !== (k < 7)) begin
                n_err++;
                $display("FAIL down_clear cyc %0d: got %h expected %h", k, obs_v, exp_v);
            end
        end
        ovf_clear = 4'b0000;
    endtask

    task automatic test_load();
        logic [7:0] ch2 [3];
        logic [7:0] ch3 [3];
        ch2 = '{8'd200, 8'd0, 8'd50};
        ch3 = '{8'd0, 8'd0, 8'd1};
        limit = 8'd9; enable = 4'b0100; up_down = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            load_valid = (k != 1);
            load_chan  = 2'd2;
            load_value = (k == 0) ? 8'd200 : 8'd50;
            if (k == 2) begin enable = 4'b1100; up_down = 4'b1100; end
            step();
            exp_v = sb.pop_front();
            obs_v = {count_out, wrap_pulse, overflow_out, any_overflow};
            n_cmp++;
            if (obs_v !== exp_v || count_out[23:16] !== ch2[k] || count_out[31:24] !== ch3[k]
                || wrap_pulse[2] !== (k == 1)) begin
                n_err++;
                $display("FAIL load cyc %0d: got %h expected %h", k, obs_v, exp_v);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_limit_zero();
        limit = 8'd0; enable = 4'b1000; up_down = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_v = sb.pop_front();
            obs_v = {count_out, wrap_pulse, overflow_out, any_overflow};
            n_cmp++;
            if (obs_v !== exp_v || count_out[31:24] !== 8'd0 || wrap_pulse[3] !== 1'b1) begin
                n_err++;
                $display("FAIL limit_zero cyc %0d: got %h expected %h", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        limit = 8'd7; enable = 4'b1111; up_down = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                reset = 1'b1; load_valid = 1'b1; load_chan = 2'd1;
                load_value = 8'd33; ovf_clear = 4'b1111;
            end
            step();
            exp_v = sb.pop_front();
            obs_v = {count_out, wrap_pulse, overflow_out, any_overflow};
            n_cmp++;
            if (obs_v !== exp_v || (k == 3 && obs_v !== 41'd0)) begin
                n_err++;
                $display("FAIL reset_mid cyc %0d: got %h expected %h", k, obs_v, exp_v);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_load_oob();
        load_valid3 = 1'b1; load_chan3 = 2'd3;
        @(posedge clock); #1;
        n_cmp++;
        if (count_out3 !== 24'd0) begin
            n_err++;
            $display("FAIL load_oob: got %h expected 000000", count_out3);
        end
        load_chan3 = 2'd2;
        @(posedge clock); #1;
        n_cmp++;
        if (count_out3 !== 24'hAA0000) begin
            n_err++;
            $display("FAIL load_in_range: got %h expected aa0000", count_out3);
        end
        load_valid3 = 1'b0;
    endtask

    task automatic test_saturate();
        logic [7:0] seq [6];
        seq = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
        limit = 8'd3; enable = 4'b0001; up_down = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) begin enable = 4'b0010; up_down = 4'b0000; end
            step();
            exp_v = sb.pop_front();
            obs_v = {count_out, wrap_pulse, overflow_out, any_overflow};
            n_cmp++;
            if (obs_v !== exp_v || (k < 6 && (count_out[7:0] !== seq[k] || wrap_pulse[0] !== (k >= 3)))
                || (k >= 6 && (count_out[15:8] !== 8'd0 || wrap_pulse[1] !== 1'b1))) begin
                n_err++;
                $display("FAIL saturate cyc %0d: got %h expected %h", k, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_count[i] = 8'd0;
        m_pulse = 4'b0000;
        m_ovf   = 4'b0000;
        reset   = 1'b1;
        idle_inputs();
        #1;
        test_reset();
`ifdef EVENT_COUNTER_BANK_SATURATE_EN
        test_saturate();
`else
        test_up_wrap();
        test_down_clear();
        test_load();
        test_limit_zero();
`endif
        test_reset_mid();
        test_load_oob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
